pc_predict_pipe: RTL and testbench

Fetch-stage PC selection and prediction block for the pipelined Y86-64 core. It replaces the single-cycle PC update with a registered predicted PC and predicts `jXX`/`call` as taken. `ret` targets are predicted from a parametrised return-address stack (RAS). It selects the real fetch PC each cycle from jump-mispredict (M stage) and ret-mispredict (W stage) corrections.

---
 rtl/pc_predict_pipe.sv | 125 ++++++++++++
 tb/tb_pc_predict_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_pipe.sv
// Fetch-stage PC selection and prediction for the pipelined Y86-64 core.
// Holds a registered predicted PC and a return-address stack (RAS).
// The real fetch PC is chosen from W-stage ret corrections, then M-stage
// jump corrections, then the prediction. jXX/call are predicted taken;
// ret targets come from the RAS. Only the RAS pointer is restored on a
// redirect. Corrupted entries show up as ret mispredicts and are fixed in W.
module pc_predict_pipe #(
  parameter int                 ADDR_W    = 64,
  parameter int                 RAS_DEPTH = 8,
  parameter int                 SP_W      = $clog2(RAS_DEPTH),
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_f_stall,
  input  logic              i_f_valid,
  input  logic [3:0]        i_f_icode,
  input  logic [ADDR_W-1:0] i_f_valC,
  input  logic [ADDR_W-1:0] i_f_valP,
  input  logic              i_m_valid,
  input  logic [3:0]        i_m_icode,
  input  logic              i_m_cnd,
  input  logic [ADDR_W-1:0] i_m_valA,
  input  logic [SP_W-1:0]   i_m_ras_sp,
  input  logic              i_w_valid,
  input  logic [3:0]        i_w_icode,
  input  logic [ADDR_W-1:0] i_w_valM,
  input  logic [ADDR_W-1:0] i_w_pred_ret,
  input  logic [SP_W-1:0]   i_w_ras_sp,
  output logic [ADDR_W-1:0] o_f_pc,
  output logic [ADDR_W-1:0] o_pred_pc,
  output logic [ADDR_W-1:0] o_f_pred_ret,
  output logic [SP_W-1:0]   o_f_ras_sp,
  output logic              o_redirect_ret,
  output logic              o_redirect_jmp
);

  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  logic [ADDR_W-1:0] r_pred_pc;
  logic [SP_W-1:0]   r_sp;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic              w_redirect_ret;
  logic              w_redirect_jmp;
  logic [SP_W-1:0]   w_bsp;
  logic [SP_W-1:0]   w_sp_inc;
  logic [SP_W-1:0]   w_sp_dec;
  logic [SP_W-1:0]   w_sp_next;
  logic [ADDR_W-1:0] w_ras_top;
  logic [ADDR_W-1:0] w_pred_next;
  logic [ADDR_W-1:0] w_f_pc;
  logic              w_push;
  logic              w_pop;
  logic              w_jxx;
  logic              w_upd;

  // W is older than M, so a ret correction suppresses the jump correction.
  assign w_redirect_ret = i_w_valid && (i_w_icode == ICODE_RET) && (i_w_valM != i_w_pred_ret);
  assign w_redirect_jmp = i_m_valid && (i_m_icode == ICODE_JXX) && !i_m_cnd && !w_redirect_ret;

  // Select fetch PC, base RAS pointer and the fetch operation on that path.
  always_comb begin
    w_f_pc = r_pred_pc;
    w_bsp  = r_sp;
    if (w_redirect_ret) begin
      w_f_pc = i_w_valM;
      w_bsp  = i_w_ras_sp;
    end else if (w_redirect_jmp) begin
      w_f_pc = i_m_valA;
      w_bsp  = i_m_ras_sp;
    end
  end

  assign w_push    = i_f_valid && (i_f_icode == ICODE_CALL);
  assign w_pop     = i_f_valid && (i_f_icode == ICODE_RET);
  assign w_jxx     = i_f_valid && (i_f_icode == ICODE_JXX);
  assign w_sp_inc  = w_bsp + SP_W'(1);
  assign w_sp_dec  = w_bsp - SP_W'(1);
  assign w_ras_top = r_ras[w_bsp];
  // A redirect always lets the corrected-path fetch update state.
  assign w_upd     = !i_f_stall || w_redirect_ret || w_redirect_jmp;

  // Next pointer and next prediction for the current fetch.
  always_comb begin
    w_sp_next   = w_bsp;
    w_pred_next = i_f_valP;
    if (w_push) begin
      w_sp_next   = w_sp_inc;
      w_pred_next = i_f_valC;
    end else if (w_pop) begin
      w_sp_next   = w_sp_dec;
      w_pred_next = w_ras_top;
    end else if (w_jxx) begin
      w_pred_next = i_f_valC;
    end
  end

  // Predicted PC, RAS pointer and RAS contents; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_pc <= RESET_PC;
      r_sp      <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_upd) begin
      r_pred_pc <= w_pred_next;
      r_sp      <= w_sp_next;
      if (w_push) begin
        r_ras[w_sp_inc] <= i_f_valP;
      end
    end
  end

  assign o_f_pc         = w_f_pc;
  assign o_pred_pc      = r_pred_pc;
  assign o_f_pred_ret   = w_ras_top;
  assign o_f_ras_sp     = w_sp_next;
  assign o_redirect_ret = w_redirect_ret;
  assign o_redirect_jmp = w_redirect_jmp;

endmodule

// File: tb/tb_pc_predict_pipe.sv
// Bench for pc_predict_pipe: directed fetch sequences with a queue of
// expected predicted PCs, plus direct checks of the combinational outputs.
module tb_pc_predict_pipe;

  localparam int ADDR_W    = 64;
  localparam int RAS_DEPTH = 8;
  localparam int SP_W      = 3;

  logic              clk;
  logic              rst_n;
  logic              f_stall, f_valid;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC, f_valP;
  logic              m_valid, m_cnd;
  logic [3:0]        m_icode;
  logic [ADDR_W-1:0] m_valA;
  logic [SP_W-1:0]   m_ras_sp;
  logic              w_valid;
  logic [3:0]        w_icode;
  logic [ADDR_W-1:0] w_valM, w_pred_ret;
  logic [SP_W-1:0]   w_ras_sp;
  logic [ADDR_W-1:0] f_pc, pred_pc, f_pred_ret;
  logic [SP_W-1:0]   f_ras_sp;
  logic              redirect_ret, redirect_jmp;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_q [$];
  int sp_m;

  pc_predict_pipe #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH), .SP_W(SP_W), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_f_stall(f_stall), .i_f_valid(f_valid), .i_f_icode(f_icode),
    .i_f_valC(f_valC), .i_f_valP(f_valP),
    .i_m_valid(m_valid), .i_m_icode(m_icode), .i_m_cnd(m_cnd),
    .i_m_valA(m_valA), .i_m_ras_sp(m_ras_sp),
    .i_w_valid(w_valid), .i_w_icode(w_icode), .i_w_valM(w_valM),
    .i_w_pred_ret(w_pred_ret), .i_w_ras_sp(w_ras_sp),
    .o_f_pc(f_pc), .o_pred_pc(pred_pc), .o_f_pred_ret(f_pred_ret),
    .o_f_ras_sp(f_ras_sp), .o_redirect_ret(redirect_ret), .o_redirect_jmp(redirect_jmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one fetch (at a negedge) and queue the pred_pc it should produce.
  task automatic drive(input logic v, input logic [3:0] ic, input logic [ADDR_W-1:0] c,
                       input logic [ADDR_W-1:0] p, input logic st, input logic [ADDR_W-1:0] expn);
    f_valid = v; f_icode = ic; f_valC = c; f_valP = p; f_stall = st;
    exp_q.push_back(expn);
    #1;
  endtask

  // Clock once and compare pred_pc against the oldest queued expectation.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) chk("queue_empty", 64'd1, 64'd0);
    else chk("pred_pc", pred_pc, exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    f_stall = 0; f_valid = 0; f_icode = 0; f_valC = 0; f_valP = 0;
    m_valid = 0; m_icode = 0; m_cnd = 0; m_valA = 0; m_ras_sp = 0;
    w_valid = 0; w_icode = 0; w_valM = 0; w_pred_ret = 0; w_ras_sp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pred_pc", pred_pc, 64'h0);
    chk("rst_f_pc", f_pc, 64'h0);
    chk("rst_f_ras_sp", 64'(f_ras_sp), 64'h0);
    @(negedge clk);

    // Call/ret pair
    drive(1, 4'h1, 0, 64'h100, 0, 64'h100); tick();
    drive(1, 4'h8, 64'h400, 64'h109, 0, 64'h400);
    chk("call_f_pc", f_pc, 64'h100);
    chk("call_sp", 64'(f_ras_sp), 64'd1);
    tick();
    drive(1, 4'h9, 0, 64'h401, 0, 64'h109);
    chk("ret_pred_ret", f_pred_ret, 64'h109);
    chk("ret_sp", 64'(f_ras_sp), 64'd0);
    tick();

    // Jump mispredict, overriding a stall; the fetch op uses the restored pointer
    drive(1, 4'h7, 64'h200, 64'h10A, 0, 64'h200);
    chk("jxx_sp", 64'(f_ras_sp), 64'd0);
    tick();
    m_valid = 1; m_icode = 4'h7; m_cnd = 0; m_valA = 64'h10A; m_ras_sp = 3'd2;
    drive(1, 4'h8, 64'h500, 64'h113, 1, 64'h500);
    chk("mj_redirect_jmp", 64'(redirect_jmp), 64'd1);
    chk("mj_redirect_ret", 64'(redirect_ret), 64'd0);
    chk("mj_f_pc", f_pc, 64'h10A);
    chk("mj_f_ras_sp", 64'(f_ras_sp), 64'd3);
    tick();
    m_valid = 0;
    drive(1, 4'h9, 0, 64'h600, 0, 64'h113);
    chk("mj_after_f_pc", f_pc, 64'h500);
    chk("mj_after_pred_ret", f_pred_ret, 64'h113);
    chk("mj_after_sp", 64'(f_ras_sp), 64'd2);
    chk("mj_after_jmp", 64'(redirect_jmp), 64'd0);
    tick();

    // Ret mispredict together with a jump mispredict: W wins
    m_valid = 1; m_icode = 4'h7; m_cnd = 0; m_valA = 64'h10A; m_ras_sp = 3'd2;
    w_valid = 1; w_icode = 4'h9; w_valM = 64'h300; w_pred_ret = 64'h109; w_ras_sp = 3'd5;
    drive(0, 4'h0, 0, 64'h50, 0, 64'h50);
    chk("wr_redirect_ret", 64'(redirect_ret), 64'd1);
    chk("wr_redirect_jmp", 64'(redirect_jmp), 64'd0);
    chk("wr_f_pc", f_pc, 64'h300);
    chk("wr_f_ras_sp", 64'(f_ras_sp), 64'd5);
    w_pred_ret = 64'h300; #1;
    chk("wok_redirect_ret", 64'(redirect_ret), 64'd0);
    chk("wok_redirect_jmp", 64'(redirect_jmp), 64'd1);
    chk("wok_f_pc", f_pc, 64'h10A);
    chk("wok_f_ras_sp", 64'(f_ras_sp), 64'd2);
    w_pred_ret = 64'h109; #1;
    tick();
    m_valid = 0; w_valid = 0;
    sp_m = 5;

    // Overflow: 9 nested calls, then 9 rets
    for (int k = 0; k < 9; k++) begin
      drive(1, 4'h8, 64'h1000 + 64'(k), 64'(16 * (k + 1)), 0, 64'h1000 + 64'(k));
      sp_m = (sp_m + 1) % RAS_DEPTH;
      chk("ovf_call_sp", 64'(f_ras_sp), 64'(sp_m));
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      logic [ADDR_W-1:0] e;
      e = (k < 8) ? 64'(16 * (9 - k)) : 64'h90;
      drive(1, 4'h9, 0, 64'hF00, 0, e);
      chk("ovf_ret_pred", f_pred_ret, e);
      sp_m = (sp_m + RAS_DEPTH - 1) % RAS_DEPTH;
      chk("ovf_ret_sp", 64'(f_ras_sp), 64'(sp_m));
      tick();
    end

    // Stall: CALL held for three cycles, then released
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'h8, 64'h888, 64'h777, 1, 64'h90);
      chk("stall_f_pc", f_pc, 64'h90);
      chk("stall_sp", 64'(f_ras_sp), 64'((sp_m + 1) % RAS_DEPTH));
      tick();
    end
    drive(1, 4'h8, 64'h888, 64'h777, 0, 64'h888); tick();
    sp_m = (sp_m + 1) % RAS_DEPTH;
    drive(1, 4'h1, 0, 64'h999, 0, 64'h999);
    chk("post_stall_sp", 64'(f_ras_sp), 64'(sp_m));
    chk("post_stall_f_pc", f_pc, 64'h888);
    tick();
    drive(1, 4'h9, 0, 64'hA00, 0, 64'h777);
    chk("post_stall_pred_ret", f_pred_ret, 64'h777);
    chk("post_stall_ret_sp", 64'(f_ras_sp), 64'((sp_m + RAS_DEPTH - 1) % RAS_DEPTH));
    tick();

    // Asynchronous reset in the middle of a push
    f_valid = 1; f_icode = 4'h8; f_valC = 64'hDEF; f_valP = 64'hABC; f_stall = 0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pred_pc", pred_pc, 64'h0);
    chk("arst_f_pc", f_pc, 64'h0);
    chk("arst_push_sp", 64'(f_ras_sp), 64'd1);
    f_valid = 0; #1;
    chk("arst_nop_sp", 64'(f_ras_sp), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 4'h9, 0, 64'hB00, 0, 64'h0);
    chk("arst_ret0_pred", f_pred_ret, 64'h0);
    chk("arst_ret0_sp", 64'(f_ras_sp), 64'd7);
    tick();
    drive(1, 4'h9, 0, 64'hB00, 0, 64'h0);
    chk("arst_ret7_pred", f_pred_ret, 64'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
